// File: rtl/scan_display_selector.sv
// scan_display_selector
// Picks one of CHANNELS packed WIDTH-bit values for the seven-segment path.
// It drives the value with a matching one-hot digit enable, either from a
// manual switch or from a prescaled auto scan that blanks between digits.
//
// state | meaning
// SHOW  | digit idx is lit; the prescaler counts 0..SCAN_DIV-1
// BLANK | all digits off for BLANK_CYC cycles; CNT/SEL hold their last values
module scan_display_selector #(
   parameter int WIDTH     = 4,
   parameter int CHANNELS  = 3,
   parameter int SEL_W     = 2,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      MODE,
   input  logic [SEL_W-1:0]          SW,
   input  logic [CHANNELS*WIDTH-1:0] CNT_BUS,
   output logic [WIDTH-1:0]          CNT,
   output logic [SEL_W-1:0]          SEL,
   output logic [CHANNELS-1:0]       DIGIT_EN
);

   localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0]    BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(CHANNELS - 1);

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } state_t;

   state_t              state_q;
   logic [SEL_W-1:0]    idx_q;
   logic [PW-1:0]       presc_q;
   logic [BW-1:0]       blank_q;
   logic                mode_q;
   logic [WIDTH-1:0]    cnt_q;
   logic [SEL_W-1:0]    sel_q;
   logic [CHANNELS-1:0] den_q;

   logic                scan_start;
   logic [SEL_W-1:0]    idx_d;
   logic [SEL_W-1:0]    idx_inc;

   // Out-of-range indices read as zero so X can never reach the decoder.
   function automatic logic [WIDTH-1:0] chan_val(input logic [SEL_W-1:0]          i,
                                                 input logic [CHANNELS*WIDTH-1:0] bus);
      chan_val = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (i == SEL_W'(k)) chan_val = bus[k*WIDTH +: WIDTH];
      end
   endfunction

   function automatic logic [CHANNELS-1:0] onehot(input logic [SEL_W-1:0] i);
      onehot = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (i == SEL_W'(k)) onehot[k] = 1'b1;
      end
   endfunction

   // Entering auto mode always starts the scan at channel 0, whatever SW held.
   always_comb begin
      scan_start = MODE & ~mode_q;
      idx_d      = scan_start ? '0 : idx_q;
      idx_inc    = (idx_d == IDX_LAST) ? '0 : idx_d + SEL_W'(1);
   end

   // Scan FSM with registered CNT/SEL/DIGIT_EN; manual mode overrides the scan.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= SHOW;
         idx_q   <= '0;
         presc_q <= '0;
         blank_q <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         sel_q   <= '0;
         den_q   <= '0;
      end else begin
         mode_q <= MODE;
         if (!MODE) begin
            state_q <= SHOW;
            idx_q   <= SW;
            presc_q <= '0;
            blank_q <= '0;
            cnt_q   <= chan_val(SW, CNT_BUS);
            sel_q   <= SW;
            den_q   <= onehot(SW);
         end else begin
            case (state_q)
               SHOW: begin
                  cnt_q <= chan_val(idx_d, CNT_BUS);
                  sel_q <= idx_d;
                  den_q <= onehot(idx_d);
                  if (presc_q == PRESC_LAST) begin
                     presc_q <= '0;
                     if (BLANK_CYC > 0) begin
                        state_q <= BLANK;
                        idx_q   <= idx_d;
                     end else begin
                        idx_q   <= idx_inc;
                     end
                  end else begin
                     presc_q <= presc_q + PW'(1);
                     idx_q   <= idx_d;
                  end
               end
               BLANK: begin
                  den_q <= '0;
                  if (blank_q == BLANK_LAST) begin
                     blank_q <= '0;
                     idx_q   <= idx_inc;
                     state_q <= SHOW;
                  end else begin
                     blank_q <= blank_q + BW'(1);
                  end
               end
               default: begin
                  state_q <= SHOW;
                  idx_q   <= '0;
                  presc_q <= '0;
                  blank_q <= '0;
                  den_q   <= '0;
               end
            endcase
         end
      end
   end

   assign CNT      = cnt_q;
   assign SEL      = sel_q;
   assign DIGIT_EN = den_q;

endmodule
